// File: rtl/data_mem_responder.sv
// Data memory answering processor load/store, with a valid/ready port that streams an image
// into memory before the program runs. Define DMEM_WR_COUNT_EN to enable the store counter.
module data_mem_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              WR,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              load_done,
    output logic [CNT_W-1:0]  wr_count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    state_e            state;
    logic [PTR_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       addr_ext;
    logic [PTR_W-1:0]  raddr;
    logic              in_range;
    logic              st_acc;
    logic              ld_acc;
    logic              ld_end;

    always_comb begin
        addr_ext = 32'(address);
        raddr    = PTR_W'(address);
        in_range = (addr_ext < DEPTH);
        st_acc   = (state != StLoad) && WR && in_range;
        ld_acc   = (state == StLoad) && ld_valid && ld_ready;
        ld_end   = ld_acc && (ld_last || (32'(ptr) == DEPTH - 1));
    end

    // Loader and processor writes are mutually exclusive by state; contents are never reset.
    always_ff @(posedge clk) begin
        if (ld_acc) begin
            mem[ptr] <= ld_data;
        end else if (st_acc) begin
            mem[raddr] <= writeData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            ptr       <= '0;
            readData  <= '0;
            ld_ready  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                StIdle, StRun: begin
                    if (!WR && MemtoReg) begin
                        readData <= in_range ? mem[raddr] : '0;
                    end
                    if (ld_start) begin
                        state    <= StLoad;
                        ptr      <= '0;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (ld_end) begin
                        state     <= StRun;
                        ptr       <= '0;
                        ld_ready  <= 1'b0;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                    end else if (ld_acc) begin
                        ptr <= ptr + PTR_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef DMEM_WR_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
        end else if (st_acc && (wr_count != {CNT_W{1'b1}})) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end
`else
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed sequences, a vector table and random
// traffic, all compared against a behavioural memory/loader model.
module tb_data_mem_responder;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] address;
    logic              WR;
    logic              MemtoReg;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              busy;
    logic              load_done;
    logic [CNT_W-1:0]  wr_count;

    data_mem_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .WR       (WR),
        .MemtoReg (MemtoReg),
        .writeData(writeData),
        .readData (readData),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .busy     (busy),
        .load_done(load_done),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: memory image, written flags, loader pointer and expected outputs.
    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    bit          m_load;
    int          m_ptr;
    logic [31:0] m_rd;
    bit          m_rd_known;
    bit          m_done;
    int          m_cnt;

    typedef struct {
        logic        wr;
        logic        m2r;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef DMEM_WR_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_load     = 0;
        m_ptr      = 0;
        m_rd       = '0;
        m_rd_known = 1;
        m_done     = 0;
        m_cnt      = 0;
    endtask

    task automatic model_edge();
        bit nd;
        nd = 0;
        if (m_load) begin
            if (ld_valid) begin
                m_mem[m_ptr] = ld_data;
                m_wr[m_ptr]  = 1;
                if (ld_last || m_ptr == DEPTH - 1) begin
                    m_load = 0;
                    m_ptr  = 0;
                    nd     = 1;
                end else begin
                    m_ptr++;
                end
            end
        end else begin
            if (WR) begin
                if (int'(address) < DEPTH) begin
                    m_mem[address] = writeData;
                    m_wr[address]  = 1;
                    if (m_cnt < CMAX) m_cnt++;
                end
            end else if (MemtoReg) begin
                if (int'(address) >= DEPTH) begin
                    m_rd       = '0;
                    m_rd_known = 1;
                end else begin
                    m_rd       = m_mem[address];
                    m_rd_known = m_wr[address];
                end
            end
            if (ld_start) begin
                m_load = 1;
                m_ptr  = 0;
            end
        end
        m_done = nd;
    endtask

    task automatic check_outputs();
        check("busy", 32'(busy), 32'(m_load));
        check("ld_ready", 32'(ld_ready), 32'(m_load));
        check("load_done", 32'(load_done), 32'(m_done));
        if (m_rd_known) check("readData", readData, m_rd);
        check("wr_count", 32'(wr_count), 32'(exp_cnt()));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic clear_in();
        address   = '0;
        WR        = 1'b0;
        MemtoReg  = 1'b0;
        writeData = '0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check("rst readData", readData, 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst ld_ready", 32'(ld_ready), 32'h0);
        check("rst load_done", 32'(load_done), 32'h0);
        check("rst wr_count", 32'(wr_count), 32'h0);
    endtask

    task automatic stream(input logic [31:0] base, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + 32'(i);
            ld_last  = last && (i == n - 1);
            step();
        end
        clear_in();
    endtask

    task automatic read_chk(input string name, input int a, input logic [31:0] exp);
        clear_in();
        MemtoReg = 1'b1;
        address  = 8'(a);
        step();
        check(name, readData, exp);
        clear_in();
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'h00, 32'h0,  32'hA0};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 32'h5,  32'hA0};
        tbl[2] = '{1'b0, 1'b1, 8'h10, 32'h0,  32'h5};
        tbl[3] = '{1'b1, 1'b1, 8'h11, 32'h7,  32'h5};
        tbl[4] = '{1'b0, 1'b1, 8'h11, 32'h0,  32'h7};
        tbl[5] = '{1'b0, 1'b0, 8'h03, 32'h0,  32'h7};
        tbl[6] = '{1'b0, 1'b1, 8'h03, 32'h0,  32'hA3};
        tbl[7] = '{1'b1, 1'b0, 8'h50, 32'h33, 32'hA3};
        tbl[8] = '{1'b0, 1'b1, 8'h50, 32'h0,  32'h0};
        tbl[9] = '{1'b0, 1'b1, 8'h10, 32'h0,  32'h5};

        clear_in();
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
        #2;
        do_reset();
        #10;
        rst = 1'b1;
        step();
        step();

        // Image load with ld_last, then read back.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("t2 busy after start", 32'(busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA0 + 32'(i);
            ld_last  = (i == 3);
            step();
            check("t2 load_done", 32'(load_done), 32'(i == 3));
        end
        check("t2 busy after last", 32'(busy), 32'h0);
        clear_in();
        step();
        check("t2 load_done drop", 32'(load_done), 32'h0);
        for (int i = 0; i < 4; i++) read_chk("t2 readback", i, 32'hA0 + 32'(i));

        // Processor vector table.
        for (int i = 0; i < 10; i++) begin
            WR        = tbl[i].wr;
            MemtoReg  = tbl[i].m2r;
            address   = tbl[i].addr;
            writeData = tbl[i].wdata;
            step();
            check($sformatf("tbl[%0d] readData", i), readData, tbl[i].exp_rd);
        end
        clear_in();

        // Processor access ignored during LOAD.
        ld_start = 1'b1;
        step();
        clear_in();
        WR        = 1'b1;
        address   = 8'h10;
        writeData = 32'h9;
        step();
        clear_in();
        MemtoReg = 1'b1;
        address  = 8'h03;
        step();
        check("t3 readData held in load", readData, 32'h5);
        clear_in();
        stream(32'hA0, 1, 1'b1);
        read_chk("t3 mem protected", 16, 32'h5);

        // Gapped full-depth load with a stray ld_start mid-stream.
        ld_start = 1'b1;
        step();
        begin
            int acc;
            int cyc;
            acc = 0;
            cyc = 0;
            while (acc < DEPTH && cyc < 8 * DEPTH) begin
                ld_valid = ($urandom_range(0, 3) != 0);
                ld_data  = 32'h1000 + 32'(acc);
                ld_start = (cyc == 20);
                ld_last  = 1'b0;
                step();
                cyc++;
                if (ld_valid) begin
                    acc++;
                    check("t4 load_done", 32'(load_done), 32'(acc == DEPTH));
                end
            end
            if (acc < DEPTH) check("t4 budget", 32'(acc), 32'(DEPTH));
        end
        clear_in();
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD;
        step();
        check("t4 extra ld_ready", 32'(ld_ready), 32'h0);
        check("t4 extra busy", 32'(busy), 32'h0);
        read_chk("t4 word 0", 0, 32'h1000);
        read_chk("t4 word 17", 17, 32'h1011);
        read_chk("t4 last word", DEPTH - 1, 32'h1000 + 32'(DEPTH - 1));

        // Reset mid-load, then restart from word 0.
        ld_start = 1'b1;
        step();
        clear_in();
        stream(32'hB0, 2, 1'b0);
        do_reset();
        step();
        rst = 1'b1;
        step();
        check("t5 ld_ready after rst", 32'(ld_ready), 32'h0);
        ld_start = 1'b1;
        step();
        clear_in();
        stream(32'hC0, 4, 1'b1);
        for (int i = 0; i < 4; i++) read_chk("t5 restart", i, 32'hC0 + 32'(i));
        read_chk("t5 untouched", 4, 32'h1004);

        // Store counter saturation and LOAD exclusion.
        for (int i = 0; i < 20; i++) begin
            WR        = 1'b1;
            address   = 8'($urandom_range(0, DEPTH - 1));
            writeData = $urandom;
            step();
        end
        clear_in();
`ifdef DMEM_WR_COUNT_EN
        check("t6 saturated", 32'(wr_count), 32'(CMAX));
`else
        check("t6 tied off", 32'(wr_count), 32'h0);
`endif
        do_reset();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WR        = 1'b1;
            address   = 8'(i + 40);
            writeData = 32'h77;
            step();
        end
        clear_in();
        ld_start = 1'b1;
        step();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            WR        = 1'b1;
            address   = 8'(i);
            writeData = 32'h55;
            step();
        end
        clear_in();
`ifdef DMEM_WR_COUNT_EN
        check("t6 load stores ignored", 32'(wr_count), 32'h3);
`else
        check("t6 load stores ignored", 32'(wr_count), 32'h0);
`endif
        stream(32'hE0, 1, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            WR        = ($urandom_range(0, 3) == 0);
            MemtoReg  = $urandom_range(0, 1);
            address   = 8'($urandom_range(0, 79));
            writeData = $urandom;
            ld_start  = ($urandom_range(0, 15) == 0);
            ld_valid  = $urandom_range(0, 1);
            ld_data   = $urandom;
            ld_last   = ($urandom_range(0, 5) == 0);
            step();
        end
        clear_in();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
